// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite slave-side bus bundle for axil_reg_responder.
// Groups the AW, W, B, AR and R channels. The clock and reset stay plain ports on the
// design.
//   master modport: drives addresses, write data, valids and response readies.
//   slave  modport: drives the address/data readies and the B/R responses.
interface axil_reg_responder_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]                      S_AXI_AWPROT;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]                      S_AXI_ARPROT;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );
endinterface

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register slave with four word registers:
//   word 0 CTRL (rw), word 1 SCRATCH (rw), word 2 STATUS (ro, STATUS_IN sampled at AR
//   handshake), word 3 WCOUNT (ro, counts accepted in-range writes). Words 4-7 are out of
//   range. Address bits [1:0] are ignored.
// Ports:
//   ACLK      - clock, rising edge
//   ARESET    - asynchronous active-high reset
//   s_axi     - AXI4-Lite slave bundle (axil_reg_responder_if.slave)
//   CTRL_OUT  - current CTRL value
//   STATUS_IN - live status word
// Build option: define AXIL_REG_RESPONDER_SLVERR_EN to answer out-of-range accesses with
// SLVERR; otherwise they answer OKAY. In both modes out-of-range writes are dropped and
// out-of-range reads return zero.
module axil_reg_responder #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   axil_reg_responder_if.slave           s_axi,
   output logic [C_S_AXI_DATA_WIDTH-1:0] CTRL_OUT,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] STATUS_IN
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;
   localparam int WB = C_S_AXI_ADDR_WIDTH - 2;

   localparam logic [WB-1:0] WORD_CTRL    = WB'(0);
   localparam logic [WB-1:0] WORD_SCRATCH = WB'(1);
   localparam logic [WB-1:0] WORD_STATUS  = WB'(2);
   localparam logic [WB-1:0] WORD_WCOUNT  = WB'(3);

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_RESPONDER_SLVERR_EN
   localparam logic [1:0] RESP_OOR = 2'b10;
`else
   localparam logic [1:0] RESP_OOR = 2'b00;
`endif

   typedef enum logic {W_IDLE, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;

   wr_state_e         wr_state;
   rd_state_e         rd_state;
   logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [1:0]        bresp_q, rresp_q;
   logic [DW-1:0]     rdata_q;
   logic [DW-1:0]     ctrl_q, scratch_q, wcount_q;

   logic [WB-1:0]     wr_word, rd_word;
   logic              wr_in_range, rd_in_range;
   logic [DW-1:0]     rd_mux;

   assign wr_word     = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign rd_word     = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign wr_in_range = (wr_word <= WORD_WCOUNT);
   assign rd_in_range = (rd_word <= WORD_WCOUNT);

   // Protection bits and sub-word address bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

   function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
      logic [DW-1:0] res;
      res = old_v;
      for (int i = 0; i < SW; i++) begin
         if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

   // Write FSM. Readies are registered: they rise the cycle after both AW and W are seen
   // valid, and the handshake completes on the following edge.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_state  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         ctrl_q    <= '0;
         scratch_q <= '0;
         wcount_q  <= '0;
      end else begin
         unique case (wr_state)
            W_IDLE: begin
               if (awready_q) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
                     if (wr_in_range) begin
                        wcount_q <= wcount_q + DW'(1);
                        case (wr_word)
                           WORD_CTRL:    ctrl_q    <= apply_strb(ctrl_q, s_axi.S_AXI_WDATA,
                                                                 s_axi.S_AXI_WSTRB);
                           WORD_SCRATCH: scratch_q <= apply_strb(scratch_q, s_axi.S_AXI_WDATA,
                                                                 s_axi.S_AXI_WSTRB);
                           default:      ; // STATUS and WCOUNT ignore writes
                        endcase
                        bresp_q <= RESP_OKAY;
                     end else begin
                        bresp_q <= RESP_OOR;
                     end
                     bvalid_q <= 1'b1;
                     wr_state <= W_RESP;
                  end
               end else if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_RESP: begin
               if (s_axi.S_AXI_BREADY) begin
                  bvalid_q <= 1'b0;
                  wr_state <= W_IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (rd_word)
         WORD_CTRL:    rd_mux = ctrl_q;
         WORD_SCRATCH: rd_mux = scratch_q;
         WORD_STATUS:  rd_mux = STATUS_IN;
         WORD_WCOUNT:  rd_mux = wcount_q;
         default:      rd_mux = '0;
      endcase
   end

   // Read FSM. Data is captured from pre-edge register values, so a read accepted on the
   // same edge as a write to the same word returns the old contents.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rd_state  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         unique case (rd_state)
            R_IDLE: begin
               if (arready_q) begin
                  arready_q <= 1'b0;
                  if (s_axi.S_AXI_ARVALID) begin
                     rdata_q  <= rd_in_range ? rd_mux : '0;
                     rresp_q  <= rd_in_range ? RESP_OKAY : RESP_OOR;
                     rvalid_q <= 1'b1;
                     rd_state <= R_DATA;
                  end
               end else if (s_axi.S_AXI_ARVALID) begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi.S_AXI_RREADY) begin
                  rvalid_q <= 1'b0;
                  rd_state <= R_IDLE;
               end
            end
         endcase
      end
   end

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign CTRL_OUT            = ctrl_q;

endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed self-checking bench for axil_reg_responder.
module tb_axil_reg_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ctrl_out;
   logic [31:0] status_in;
   int          n_cmp  = 0;
   int          n_fail = 0;

`ifdef AXIL_REG_RESPONDER_SLVERR_EN
   localparam logic [1:0] EXP_OOR = 2'b10;
`else
   localparam logic [1:0] EXP_OOR = 2'b00;
`endif

   axil_reg_responder_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) s_axi ();

   axil_reg_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
      .ACLK      (clk),
      .ARESET    (rst),
      .s_axi     (s_axi),
      .CTRL_OUT  (ctrl_out),
      .STATUS_IN (status_in)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full write with BREADY high; reports handshake seen, BVALID one cycle after the
   // handshake, the BRESP seen then, and BVALID cleared on the next cycle.
   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output bit hs, output bit bv,
                            output logic [1:0] resp, output bit clr);
      int cyc;
      hs = 1'b0; bv = 1'b0; clr = 1'b0; resp = 2'b11; cyc = 0;
      s_axi.S_AXI_AWADDR  = addr;
      s_axi.S_AXI_WDATA   = data;
      s_axi.S_AXI_WSTRB   = strb;
      s_axi.S_AXI_AWVALID = 1'b1;
      s_axi.S_AXI_WVALID  = 1'b1;
      s_axi.S_AXI_BREADY  = 1'b1;
      while (!hs && cyc < 10) begin
         tick();
         cyc++;
         if (s_axi.S_AXI_AWREADY && s_axi.S_AXI_WREADY) hs = 1'b1;
      end
      if (hs) begin
         tick();
         s_axi.S_AXI_AWVALID = 1'b0;
         s_axi.S_AXI_WVALID  = 1'b0;
         bv   = s_axi.S_AXI_BVALID;
         resp = s_axi.S_AXI_BRESP;
         tick();
         clr = !s_axi.S_AXI_BVALID;
      end
      s_axi.S_AXI_AWVALID = 1'b0;
      s_axi.S_AXI_WVALID  = 1'b0;
      s_axi.S_AXI_BREADY  = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] addr, output bit hs, output bit rv,
                           output logic [31:0] data, output logic [1:0] resp);
      int cyc;
      hs = 1'b0; rv = 1'b0; data = 32'hx; resp = 2'b11; cyc = 0;
      s_axi.S_AXI_ARADDR  = addr;
      s_axi.S_AXI_ARVALID = 1'b1;
      s_axi.S_AXI_RREADY  = 1'b1;
      while (!hs && cyc < 10) begin
         tick();
         cyc++;
         if (s_axi.S_AXI_ARREADY) hs = 1'b1;
      end
      if (hs) begin
         tick();
         s_axi.S_AXI_ARVALID = 1'b0;
         rv   = s_axi.S_AXI_RVALID;
         data = s_axi.S_AXI_RDATA;
         resp = s_axi.S_AXI_RRESP;
         tick();
      end
      s_axi.S_AXI_ARVALID = 1'b0;
      s_axi.S_AXI_RREADY  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_BVALID,
           s_axi.S_AXI_ARREADY, s_axi.S_AXI_RVALID} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_handshake: got %b required 00000",
                  {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_BVALID,
                   s_axi.S_AXI_ARREADY, s_axi.S_AXI_RVALID});
      end
      n_cmp++;
      if ({s_axi.S_AXI_BRESP, s_axi.S_AXI_RRESP} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_resp: got %b required 0000",
                  {s_axi.S_AXI_BRESP, s_axi.S_AXI_RRESP});
      end
      n_cmp++;
      if (s_axi.S_AXI_RDATA !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h required 00000000", s_axi.S_AXI_RDATA);
      end
      n_cmp++;
      if (ctrl_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %h required 00000000", ctrl_out);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_ctrl();
      bit hs, bv, clr, rhs, rv;
      logic [1:0]  resp, rresp;
      logic [31:0] rdata;
      axi_write(5'h00, 32'hA5A5_1234, 4'hF, hs, bv, resp, clr);
      n_cmp++;
      if ({hs, bv, clr} !== 3'b111) begin
         n_fail++;
         $display("FAIL wr_ctrl_timing: hs/bv/clr got %b%b%b required 111", hs, bv, clr);
      end
      n_cmp++;
      if (resp !== 2'b00) begin
         n_fail++;
         $display("FAIL wr_ctrl_bresp: got %b required 00", resp);
      end
      n_cmp++;
      if (ctrl_out !== 32'hA5A5_1234) begin
         n_fail++;
         $display("FAIL wr_ctrl_out: got %h required a5a51234", ctrl_out);
      end
      axi_read(5'h0C, rhs, rv, rdata, rresp);
      n_cmp++;
      if ({rhs, rv, rdata} !== {2'b11, 32'd1}) begin
         n_fail++;
         $display("FAIL wr_ctrl_wcount: got %0d (hs=%b rv=%b) required 1", rdata, rhs, rv);
      end
   endtask

   task automatic test_strobe();
      bit hs, bv, clr, rhs, rv;
      logic [1:0]  resp, rresp;
      logic [31:0] rdata;
      axi_write(5'h04, 32'hFFFF_FFFF, 4'h2, hs, bv, resp, clr);
      axi_read(5'h04, rhs, rv, rdata, rresp);
      n_cmp++;
      if ({rhs, rv, rdata} !== {2'b11, 32'h0000_FF00}) begin
         n_fail++;
         $display("FAIL strobe_rdata: got %h (hs=%b rv=%b) required 0000ff00", rdata, rhs, rv);
      end
      n_cmp++;
      if (rresp !== 2'b00) begin
         n_fail++;
         $display("FAIL strobe_rresp: got %b required 00", rresp);
      end
   endtask

   task automatic test_aw_before_w();
      s_axi.S_AXI_AWADDR  = 5'h00;
      s_axi.S_AXI_WDATA   = 32'h0000_0055;
      s_axi.S_AXI_WSTRB   = 4'h1;
      s_axi.S_AXI_AWVALID = 1'b1;
      s_axi.S_AXI_WVALID  = 1'b0;
      s_axi.S_AXI_BREADY  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY} !== 2'b00) begin
            n_fail++;
            $display("FAIL aw_only_wait[%0d]: ready got %b required 00", i,
                     {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY});
         end
      end
      s_axi.S_AXI_WVALID = 1'b1;
      tick();
      n_cmp++;
      if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY} !== 2'b11) begin
         n_fail++;
         $display("FAIL aw_w_ready: got %b required 11",
                  {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY});
      end
      tick();
      s_axi.S_AXI_AWVALID = 1'b0;
      s_axi.S_AXI_WVALID  = 1'b0;
      n_cmp++;
      if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_BVALID} !== 3'b001) begin
         n_fail++;
         $display("FAIL aw_w_pulse: aw/w/b got %b required 001",
                  {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_BVALID});
      end
      tick();
      s_axi.S_AXI_BREADY = 1'b0;
      n_cmp++;
      if (ctrl_out !== 32'hA5A5_1255) begin
         n_fail++;
         $display("FAIL aw_w_ctrl: got %h required a5a51255", ctrl_out);
      end
   endtask

   task automatic test_status();
      bit hs, bv, clr, rhs, rv;
      logic [1:0]  resp, rresp;
      logic [31:0] rdata;
      status_in = 32'hDEAD_BEEF;
      axi_write(5'h08, 32'h0, 4'hF, hs, bv, resp, clr);
      n_cmp++;
      if ({hs, bv, resp} !== 4'b1100) begin
         n_fail++;
         $display("FAIL status_wr: hs/bv/bresp got %b%b%b required 1100", hs, bv, resp);
      end
      axi_read(5'h08, rhs, rv, rdata, rresp);
      n_cmp++;
      if (rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL status_rd: got %h required deadbeef", rdata);
      end
      axi_read(5'h0C, rhs, rv, rdata, rresp);
      n_cmp++;
      if (rdata !== 32'd4) begin
         n_fail++;
         $display("FAIL status_wcount: got %0d required 4", rdata);
      end
   endtask

   task automatic test_read_stall();
      bit hs, bv, clr, rhs;
      logic [1:0] resp;
      int cyc;
      axi_write(5'h04, 32'h11, 4'hF, hs, bv, resp, clr);
      s_axi.S_AXI_ARADDR  = 5'h04;
      s_axi.S_AXI_ARVALID = 1'b1;
      s_axi.S_AXI_RREADY  = 1'b0;
      rhs = 1'b0; cyc = 0;
      while (!rhs && cyc < 10) begin
         tick();
         cyc++;
         if (s_axi.S_AXI_ARREADY) rhs = 1'b1;
      end
      n_cmp++;
      if (!rhs) begin
         n_fail++;
         $display("FAIL stall_arready: got 0 required 1 within 10 cycles");
      end
      tick();
      s_axi.S_AXI_ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA} !== {1'b1, 32'h11}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: rvalid=%b rdata=%h required 1 00000011", i,
                     s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA);
         end
         tick();
      end
      s_axi.S_AXI_RREADY = 1'b1;
      tick();
      s_axi.S_AXI_RREADY = 1'b0;
      n_cmp++;
      if (s_axi.S_AXI_RVALID !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release: rvalid got %b required 0", s_axi.S_AXI_RVALID);
      end
   endtask

   task automatic test_simultaneous();
      bit hs, rv;
      logic [1:0]  rresp;
      logic [31:0] rdata;
      int cyc;
      s_axi.S_AXI_AWADDR  = 5'h04;
      s_axi.S_AXI_WDATA   = 32'h22;
      s_axi.S_AXI_WSTRB   = 4'hF;
      s_axi.S_AXI_ARADDR  = 5'h04;
      s_axi.S_AXI_AWVALID = 1'b1;
      s_axi.S_AXI_WVALID  = 1'b1;
      s_axi.S_AXI_ARVALID = 1'b1;
      s_axi.S_AXI_BREADY  = 1'b1;
      s_axi.S_AXI_RREADY  = 1'b1;
      hs = 1'b0; cyc = 0;
      while (!hs && cyc < 10) begin
         tick();
         cyc++;
         if (s_axi.S_AXI_AWREADY && s_axi.S_AXI_ARREADY) hs = 1'b1;
      end
      tick();
      s_axi.S_AXI_AWVALID = 1'b0;
      s_axi.S_AXI_WVALID  = 1'b0;
      s_axi.S_AXI_ARVALID = 1'b0;
      n_cmp++;
      if ({hs, s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA}
          !== {3'b111, 32'h11}) begin
         n_fail++;
         $display("FAIL simul_old_value: hs=%b bv=%b rv=%b rdata=%h required 1 1 1 00000011",
                  hs, s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA);
      end
      tick();
      s_axi.S_AXI_BREADY = 1'b0;
      s_axi.S_AXI_RREADY = 1'b0;
      axi_read(5'h04, hs, rv, rdata, rresp);
      n_cmp++;
      if (rdata !== 32'h22) begin
         n_fail++;
         $display("FAIL simul_new_value: got %h required 00000022", rdata);
      end
   endtask

   task automatic test_out_of_range();
      bit hs, bv, clr, rhs, rv;
      logic [1:0]  resp, rresp;
      logic [31:0] rdata;
      axi_write(5'h10, 32'h1234_5678, 4'hF, hs, bv, resp, clr);
      n_cmp++;
      if ({hs, bv, resp} !== {2'b11, EXP_OOR}) begin
         n_fail++;
         $display("FAIL oor_bresp: hs/bv/bresp got %b%b%b required 11%b", hs, bv, resp, EXP_OOR);
      end
      axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, hs, bv, resp, clr);
      axi_read(5'h10, rhs, rv, rdata, rresp);
      n_cmp++;
      if ({rhs, rv, rresp, rdata} !== {2'b11, EXP_OOR, 32'h0}) begin
         n_fail++;
         $display("FAIL oor_read: rresp=%b rdata=%h required %b 00000000", rresp, rdata, EXP_OOR);
      end
      axi_read(5'h0C, rhs, rv, rdata, rresp);
      n_cmp++;
      if (rdata !== 32'd6) begin
         n_fail++;
         $display("FAIL oor_wcount: got %0d required 6", rdata);
      end
      n_cmp++;
      if (ctrl_out !== 32'hA5A5_1255) begin
         n_fail++;
         $display("FAIL oor_ctrl: got %h required a5a51255", ctrl_out);
      end
   endtask

   task automatic test_reset_mid();
      bit hs, rv;
      logic [1:0]  rresp;
      logic [31:0] rdata;
      int cyc;
      s_axi.S_AXI_AWADDR  = 5'h00;
      s_axi.S_AXI_WDATA   = 32'hCAFE_0001;
      s_axi.S_AXI_WSTRB   = 4'hF;
      s_axi.S_AXI_AWVALID = 1'b1;
      s_axi.S_AXI_WVALID  = 1'b1;
      s_axi.S_AXI_BREADY  = 1'b0;
      hs = 1'b0; cyc = 0;
      while (!hs && cyc < 10) begin
         tick();
         cyc++;
         if (s_axi.S_AXI_AWREADY) hs = 1'b1;
      end
      tick();
      s_axi.S_AXI_AWVALID = 1'b0;
      s_axi.S_AXI_WVALID  = 1'b0;
      n_cmp++;
      if ({s_axi.S_AXI_BVALID, ctrl_out} !== {1'b1, 32'hCAFE_0001}) begin
         n_fail++;
         $display("FAIL midrst_pre: bvalid=%b ctrl=%h required 1 cafe0001",
                  s_axi.S_AXI_BVALID, ctrl_out);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({s_axi.S_AXI_BVALID, ctrl_out} !== 33'h0) begin
         n_fail++;
         $display("FAIL midrst_async: bvalid=%b ctrl=%h required 0 00000000",
                  s_axi.S_AXI_BVALID, ctrl_out);
      end
      tick();
      tick();
      rst = 1'b0;
      s_axi.S_AXI_BREADY = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (s_axi.S_AXI_BVALID !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_no_resp: bvalid got %b required 0", s_axi.S_AXI_BVALID);
      end
      s_axi.S_AXI_BREADY = 1'b0;
      axi_read(5'h0C, hs, rv, rdata, rresp);
      n_cmp++;
      if ({hs, rv, rdata} !== {2'b11, 32'd0}) begin
         n_fail++;
         $display("FAIL midrst_wcount: got %0d (hs=%b rv=%b) required 0", rdata, hs, rv);
      end
   endtask

   task automatic test_back_to_back();
      bit hs, bv, clr, rhs, rv;
      logic [1:0]  resp, rresp;
      logic [31:0] rdata;
      axi_write(5'h00, 32'h0000_0001, 4'hF, hs, bv, resp, clr);
      axi_write(5'h04, 32'h0000_0002, 4'hF, hs, bv, resp, clr);
      axi_read(5'h00, rhs, rv, rdata, rresp);
      n_cmp++;
      if (rdata !== 32'h1) begin
         n_fail++;
         $display("FAIL b2b_ctrl: got %h required 00000001", rdata);
      end
      axi_read(5'h04, rhs, rv, rdata, rresp);
      n_cmp++;
      if (rdata !== 32'h2) begin
         n_fail++;
         $display("FAIL b2b_scratch: got %h required 00000002", rdata);
      end
      axi_read(5'h0C, rhs, rv, rdata, rresp);
      n_cmp++;
      if (rdata !== 32'd2) begin
         n_fail++;
         $display("FAIL b2b_wcount: got %0d required 2", rdata);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                 = 1'b1;
      status_in           = 32'h0;
      s_axi.S_AXI_AWADDR  = '0;
      s_axi.S_AXI_AWPROT  = 3'b0;
      s_axi.S_AXI_AWVALID = 1'b0;
      s_axi.S_AXI_WDATA   = '0;
      s_axi.S_AXI_WSTRB   = '0;
      s_axi.S_AXI_WVALID  = 1'b0;
      s_axi.S_AXI_BREADY  = 1'b0;
      s_axi.S_AXI_ARADDR  = '0;
      s_axi.S_AXI_ARPROT  = 3'b0;
      s_axi.S_AXI_ARVALID = 1'b0;
      s_axi.S_AXI_RREADY  = 1'b0;
      test_reset();
      test_write_ctrl();
      test_strobe();
      test_aw_before_w();
      test_status();
      test_read_stall();
      test_simultaneous();
      test_out_of_range();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
